fanout_update_scheduler: RTL
============================

// Module: fanout_update_scheduler
// PURPOSE
// - Drives a wide fanout of one logic signal (default 20 copies) as registered outputs.
// - Limits simultaneous switching: a change on in reaches the outputs one group of GROUP_SIZE per clock, round-robin.
// - Sits between a single high-fanout source net and its N_OUT loads, in place of a flat inverter fanout.
// PARAMETERS
// - N_OUT       20  number of output copies (>=1)
// - GROUP_SIZE  4   max outputs allowed to switch in one cycle (1..N_OUT)
// - NUM_GROUPS  derived = ceil(N_OUT/GROUP_SIZE); not user-overridable
// PORTS
// - clk    in   1      single clock; all state on rising edge
// - rst_n  in   1      synchronous, active-low reset
// - in     in   1      source level; sampled every cycle, already synchronous to clk
// - out    out  N_OUT  fanout copies; out[i] converges to the sampled in
// - busy   out  1      1 while any group is pending update
// - done   out  1      one-cycle pulse when the last pending group is written
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): out=0, target=0, busy=0, done=0, grp_ptr=0, state=IDLE. Reset dominates everything else.
// - target: register, loads in every cycle; change = (in != target) at a posedge.
// - Group g covers out[g*GROUP_SIZE +: GROUP_SIZE], clipped at N_OUT-1; the last group may be partial (e.g. N_OUT=20, GROUP_SIZE=6: groups of 6,6,6,2).
// - FSM states:
//   - IDLE: on change -> UPDATE, grp_ptr=0, busy=1 on next cycle.
//   - UPDATE: each cycle writes target into group grp_ptr; grp_ptr++.
//     - When the written group is NUM_GROUPS-1 -> IDLE, busy=0, done=1 for exactly that cycle.
// - Latency: change sampled at edge k; group 0 is written at k+1; last group at k+NUM_GROUPS; busy is high for NUM_GROUPS cycles.
// - Restart on change mid-UPDATE (in != target while busy): target reloads, grp_ptr restarts at 0.
//   - The group scheduled that cycle is still written, with the new target.
//   - done is not pulsed; busy stays 1.
// - No more than GROUP_SIZE bits of out change on any edge. Groups not addressed hold their value.
// - in equal to target in IDLE: no activity. A glitch that reverts before being sampled is invisible.
// - N_OUT == GROUP_SIZE: single group; latency is 1 cycle and done pulses with the update.
// - Steady state: out == {N_OUT{target}} whenever busy=0 after the first update.
// CONFIGURATION
// - Macro FANOUT_SKIP_CLEAN_EN.
// - Defined: in UPDATE, grp_ptr jumps to the lowest-indexed group (>= current) whose bits differ from target.
//   - If no such group remains -> IDLE with done=1.
//   - Latency = number of dirty groups. Still at most one group written per cycle.
// - Undefined: every group is visited in order; latency is fixed at NUM_GROUPS.
// STRUCTURE
// - Package fanout_sched_pkg:
//   - state_t enum {IDLE, UPDATE};
//   - function ceil_div(int a, int b).
// - Sub-module fanout_group_mask (combinational):
//   - inputs: grp_ptr; parameters N_OUT, GROUP_SIZE;
//   - output: N_OUT-bit one-group write mask.
//   - Reused for the dirty-group search under FANOUT_SKIP_CLEAN_EN.
// TESTING
// - Reset: hold rst_n=0 3 cycles with in=1 -> out=0, busy=0, done=0. Release -> group 0 written in the 2nd cycle.
// - Defaults, in 0->1 at edge k -> out bits[3:0] set at k+1 ... bits[19:16] at k+5; done=1 at k+5 only; never >4 bits toggle per edge.
// - N_OUT=20, GROUP_SIZE=6 -> 4 groups, last group is bits[19:18]; done after 4 cycles.
// - in 0->1, then 1->0 at the 3rd UPDATE cycle -> ptr restarts at 0, no done at the original k+5, final out=0, busy drops after 5 more cycles.
// - rst_n=0 mid-UPDATE -> next cycle out=0, busy=0, done=0, state IDLE.
// - FANOUT_SKIP_CLEAN_EN, out preset so only group 3 is stale, in changes ->
//   - group 3 written one cycle after the change is sampled; done on that cycle; busy high 1 cycle.

Source files
------------

// File: rtl/fanout_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fanout_sched_pkg
// Description : Shared types and helpers for the fanout update scheduler.
//               - state_t  : scheduler FSM state encoding
//               - ceil_div : integer ceiling division, used for the group count
// Revision    : 1.0 - initial release
// ============================================================================
package fanout_sched_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage : fanout_sched_pkg
`default_nettype wire

// File: rtl/fanout_group_mask.sv
`default_nettype none
// ============================================================================
// Module      : fanout_group_mask
// Description : Combinational decoder from a group index to an N_OUT-bit
//               one-group write mask. Group g covers bits
//               [g*GROUP_SIZE +: GROUP_SIZE], clipped at N_OUT-1, so the last
//               group may be partial.
// Ports       : i_grp_ptr  in   PTR_W  group index
//               o_mask     out  N_OUT  1 for every bit belonging to the group
// Revision    : 1.0 - initial release
// ============================================================================
module fanout_group_mask #(
  parameter int N_OUT      = 20,
  parameter int GROUP_SIZE = 4,
  parameter int PTR_W      = 3
) (
  input  logic [PTR_W-1:0] i_grp_ptr,
  output logic [N_OUT-1:0] o_mask
);

  for (genvar i = 0; i < N_OUT; i++) begin : g_bit
    localparam logic [PTR_W-1:0] c_grp_idx = PTR_W'(i / GROUP_SIZE);
    assign o_mask[i] = (i_grp_ptr == c_grp_idx);
  end

endmodule : fanout_group_mask
`default_nettype wire

// File: rtl/fanout_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fanout_update_scheduler
// Description : Registered wide fanout of one signal. A change on `in` is
//               propagated to `out` one group of GROUP_SIZE bits per clock,
//               round-robin, to bound simultaneous switching.
// Ports       : clk    in   1      clock, rising edge
//               rst_n  in   1      synchronous active-low reset
//               in     in   1      source level (already synchronous)
//               out    out  N_OUT  fanout copies
//               busy   out  1      high while a group update is pending
//               done   out  1      one-cycle pulse when the last group lands
// Options     : FANOUT_SKIP_CLEAN_EN - when defined, groups that already hold
//               the target level are skipped, so latency equals the number of
//               dirty groups. Undefined: every group visited in order.
// Revision    : 1.0 - initial release
// ============================================================================
import fanout_sched_pkg::*;

module fanout_update_scheduler #(
  parameter int N_OUT      = 20,
  parameter int GROUP_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [N_OUT-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int NUM_GROUPS = ceil_div(N_OUT, GROUP_SIZE);
  localparam int PTR_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_GROUPS - 1);

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic               r_target;
  logic               r_done, w_done_nxt;
  logic [N_OUT-1:0]   r_out, w_out_nxt;
  logic [N_OUT-1:0]   w_mask;
  logic [N_OUT-1:0]   w_out_wr;
  logic               w_change;

  assign w_change = in ^ r_target;

  fanout_group_mask #(
    .N_OUT      (N_OUT),
    .GROUP_SIZE (GROUP_SIZE),
    .PTR_W      (PTR_W)
  ) u_wr_mask (
    .i_grp_ptr (r_ptr),
    .o_mask    (w_mask)
  );

  // The scheduled group always receives the freshly sampled level. Without a
  // change this equals target; on a restart it is the new target.
  assign w_out_wr = (r_out & ~w_mask) | ({N_OUT{in}} & w_mask);

`ifdef FANOUT_SKIP_CLEAN_EN
  logic [N_OUT-1:0]      w_out_base;
  logic [NUM_GROUPS-1:0] w_dirty;
  logic [PTR_W:0]        w_start;
  logic                  w_found;
  logic [PTR_W-1:0]      w_first;

  // Dirtiness is judged on the value out will hold after this edge, so the
  // group being written now never counts as still stale.
  assign w_out_base = (r_state == UPDATE) ? w_out_wr : r_out;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_dirty
    logic [N_OUT-1:0] w_gmask;
    fanout_group_mask #(
      .N_OUT      (N_OUT),
      .GROUP_SIZE (GROUP_SIZE),
      .PTR_W      (PTR_W)
    ) u_dirty_mask (
      .i_grp_ptr (PTR_W'(g)),
      .o_mask    (w_gmask)
    );
    assign w_dirty[g] = |((w_out_base ^ {N_OUT{in}}) & w_gmask);
  end

  // Search restarts at group 0 on a new change; otherwise it continues past
  // the group being written. Extra bit keeps LAST+1 from wrapping to 0.
  assign w_start = ((r_state == IDLE) || w_change) ? '0
                 : ({1'b0, r_ptr} + (PTR_W+1)'(1));

  always_comb begin
    w_found = 1'b0;
    w_first = '0;
    // Descending scan so the lowest qualifying index wins.
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (w_dirty[g] && ((PTR_W+1)'(g) >= w_start)) begin
        w_found = 1'b1;
        w_first = PTR_W'(g);
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    w_out_nxt   = r_out;
    unique case (r_state)
      IDLE: begin
        if (w_change) begin
`ifdef FANOUT_SKIP_CLEAN_EN
          if (w_found) begin
            w_state_nxt = UPDATE;
            w_ptr_nxt   = w_first;
          end
`else
          w_state_nxt = UPDATE;
          w_ptr_nxt   = '0;
`endif
        end
      end
      UPDATE: begin
        w_out_nxt = w_out_wr;
`ifdef FANOUT_SKIP_CLEAN_EN
        if (w_found) begin
          w_ptr_nxt = w_first;
        end else begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
`else
        if (w_change) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == c_LAST) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_target <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_target <= in;
      r_done   <= w_done_nxt;
      r_out    <= w_out_nxt;
    end
  end

  assign out  = r_out;
  assign busy = (r_state == UPDATE);
  assign done = r_done;

endmodule : fanout_update_scheduler
`default_nettype wire
